act_requant: RTL and testbench

ACT_REQUANT -- requirements
Module: act_requant

---
 rtl/act_requant.sv | 182 ++++++++++++++++++
 tb/tb_act_requant.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_requant.sv
// act_requant: collects M signed accumulator values from an upstream serial
// stream, applies optional ReLU, rounding arithmetic right shift and
// saturation to DATA_WIDTH. When a frame is complete it presents the packed
// vector with the index of its largest element and holds it until the
// consumer acknowledges.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    signed ACC_WIDTH element from upstream
//   in_valid   in_data valid this cycle
//   in_done    end-of-frame pulse
//   out_vec    packed vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   vec_valid  out_vec / max_idx hold a complete frame
//   vec_ack    consumer has taken the vector
//   max_idx    index of largest element (lowest index on ties)
//   busy       frame partially collected
//   err        sticky protocol-error flag
module act_requant #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int M          = 3,
    parameter int SHIFT      = 0,
    parameter int RELU       = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic signed [ACC_WIDTH-1:0]          in_data,
    input  logic                                 in_valid,
    input  logic                                 in_done,
    output logic [M*DATA_WIDTH-1:0]              out_vec,
    output logic                                 vec_valid,
    input  logic                                 vec_ack,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] max_idx,
    output logic                                 busy,
    output logic                                 err
);

    localparam int CW      = $clog2(M + 1);
    localparam int IDX_W   = (M > 1) ? $clog2(M) : 1;
    localparam int AW1     = ACC_WIDTH + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [CW-1:0] CNT_FULL = CW'(M);

    // Half-LSB of the shifted result, giving round-half-up.
    localparam logic signed [ACC_WIDTH:0] RND =
        (SHIFT > 0) ? (AW1'(1) << RND_POS) : '0;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic signed [DATA_WIDTH-1:0]  elem_q [M];
    logic signed [DATA_WIDTH-1:0]  elem_d [M];

    logic signed [ACC_WIDTH:0]     x_ext;
    logic signed [ACC_WIDTH:0]     sum;
    logic signed [ACC_WIDTH:0]     shifted;
    logic signed [DATA_WIDTH-1:0]  res;

    // Requantise the incoming element.
    always_comb begin
        x_ext = {in_data[ACC_WIDTH-1], in_data};
        if ((RELU != 0) && in_data[ACC_WIDTH-1]) begin
            x_ext = '0;
        end
        sum     = x_ext + RND;
        shifted = sum >>> SHIFT;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            res = shifted[DATA_WIDTH-1:0];
        end
    end

    // Next-state logic. in_done is judged on the count after any
    // same-cycle write, so cnt_w carries the post-write count.
    logic [CW-1:0] cnt_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cnt_w   = cnt_q;
        for (int unsigned i = 0; i < M; i++) begin
            elem_d[i] = elem_q[i];
        end
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (cnt_q < CNT_FULL) begin
                        for (int unsigned i = 0; i < M; i++) begin
                            if (cnt_q == CW'(i)) begin
                                elem_d[i] = res;
                            end
                        end
                        cnt_w = cnt_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                cnt_d = cnt_w;
                if (in_done) begin
                    if (cnt_w == CNT_FULL) begin
                        state_d = HOLD;
                    end else begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (in_valid || in_done) begin
                    err_d = 1'b1;
                end
                if (vec_ack) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < M; i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < M; i++) begin
                elem_q[i] <= elem_d[i];
            end
        end
    end

    // Argmax over the stored elements; strict '>' keeps the lowest index on ties.
    logic signed [DATA_WIDTH-1:0] best;

    always_comb begin
        best    = elem_q[0];
        max_idx = '0;
        for (int unsigned i = 1; i < M; i++) begin
            if (elem_q[i] > best) begin
                best    = elem_q[i];
                max_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        out_vec = '0;
        for (int unsigned i = 0; i < M; i++) begin
            out_vec[i*DATA_WIDTH +: DATA_WIDTH] = elem_q[i];
        end
    end

    assign vec_valid = (state_q == HOLD);
    assign busy      = (state_q == COLLECT) && (cnt_q != '0);
    assign err       = err_q;

endmodule

// File: tb/tb_act_requant.sv
module tb_act_requant;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_done = 1'b0;
    logic               vec_ack = 1'b0;

    logic [23:0] ov [3];
    logic        vv [3];
    logic [1:0]  mi [3];
    logic        bz [3];
    logic        er [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    act_requant u_def (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_done(in_done), .out_vec(ov[0]), .vec_valid(vv[0]),
        .vec_ack(vec_ack), .max_idx(mi[0]), .busy(bz[0]), .err(er[0])
    );

    act_requant #(.RELU(0)) u_norelu (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_done(in_done), .out_vec(ov[1]), .vec_valid(vv[1]),
        .vec_ack(vec_ack), .max_idx(mi[1]), .busy(bz[1]), .err(er[1])
    );

    act_requant #(.SHIFT(2), .RELU(0)) u_shift (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_done(in_done), .out_vec(ov[2]), .vec_valid(vv[2]),
        .vec_ack(vec_ack), .max_idx(mi[2]), .busy(bz[2]), .err(er[2])
    );

    // Behavioural model: raw accumulator values per slot, frame fill count,
    // hold flag and sticky error. Requantisation is applied at compare time.
    longint m_raw [3];
    int     m_cnt;
    bit     m_hold;
    bit     m_err;
    int     cfg_shift [3] = '{0, 0, 2};
    bit     cfg_relu  [3] = '{1'b1, 1'b0, 1'b0};

    function automatic int ref_rq(longint v, int sh, bit relu);
        longint x, p, num, q;
        x = (relu && v < 0) ? 0 : v;
        p = 1;
        repeat (sh) p = p * 2;
        num = x + ((sh > 0) ? p / 2 : 0);
        q = num / p;
        if (num < 0 && (num % p) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    function automatic logic [23:0] ref_vec(int k);
        logic [23:0] v;
        for (int i = 0; i < 3; i++) v[i*8 +: 8] = 8'(ref_rq(m_raw[i], cfg_shift[k], cfg_relu[k]));
        return v;
    endfunction

    function automatic logic [1:0] ref_max(int k);
        int best, b;
        logic [1:0] idx;
        best = ref_rq(m_raw[0], cfg_shift[k], cfg_relu[k]);
        idx = 2'd0;
        for (int i = 1; i < 3; i++) begin
            b = ref_rq(m_raw[i], cfg_shift[k], cfg_relu[k]);
            if (b > best) begin
                best = b;
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    task automatic model_step(input bit v, input bit d, input bit a, input longint data);
        if (!m_hold) begin
            if (v) begin
                if (m_cnt < 3) begin
                    m_raw[m_cnt] = data;
                    m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (d) begin
                if (m_cnt == 3) m_hold = 1'b1;
                else begin
                    m_err = 1'b1;
                    m_cnt = 0;
                end
            end
        end else begin
            if (v || d) m_err = 1'b1;
            if (a) begin
                m_hold = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step(input bit v, input bit d, input bit a, input int data);
        in_valid = v;
        in_done  = d;
        vec_ack  = a;
        in_data  = data;
        @(posedge clk);
        #1;
        model_step(v, d, a, longint'(data));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_done = 1'b0;
        vec_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) m_raw[i] = 0;
        m_cnt = 0;
        m_hold = 1'b0;
        m_err = 1'b0;
    endtask

    function automatic int rand_acc();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 800)) - 400;
    endfunction

    task automatic test_reset();
        // rst wins over every other input
        rst = 1'b1;
        in_valid = 1'b1;
        in_done = 1'b1;
        vec_ack = 1'b1;
        in_data = 55;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({vv[k], ov[k], mi[k], bz[k], er[k]} !== 29'd0) begin
                errors++;
                $display("FAIL reset dut%0d got %h exp 0", k, {vv[k], ov[k], mi[k], bz[k], er[k]});
            end
        end
        do_reset();
    endtask

    task automatic test_directed();
        step(1, 0, 0, 15);
        checks++;
        if ({vv[0], bz[0]} !== 2'b01) begin
            errors++;
            $display("FAIL busy_first got %b exp 01", {vv[0], bz[0]});
        end
        step(1, 0, 0, 30);
        step(1, 1, 0, 45);
        checks++;
        if ({vv[0], ov[0], mi[0], er[0], bz[0]} !== {1'b1, 24'h2d1e0f, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL frame_15_30_45 got %h exp %h", {vv[0], ov[0], mi[0], er[0], bz[0]},
                     {1'b1, 24'h2d1e0f, 2'd2, 1'b0, 1'b0});
        end
        step(0, 0, 1, 0);
        checks++;
        if (vv[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_clears got %b exp 0", vv[0]);
        end

        step(1, 0, 0, -7);
        step(1, 0, 0, 2);
        step(1, 0, 0, 300);
        checks++;
        if ({vv[0], bz[0]} !== 2'b01) begin
            errors++;
            $display("FAIL full_not_done got %b exp 01", {vv[0], bz[0]});
        end
        step(0, 1, 0, 0);
        checks++;
        if ({vv[0], ov[0], mi[0], er[0]} !== {1'b1, 24'h7f0200, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL relu_sat got %h exp %h", {vv[0], ov[0], mi[0], er[0]}, {1'b1, 24'h7f0200, 2'd2, 1'b0});
        end
        step(0, 0, 1, 0);

        step(1, 0, 0, -300);
        step(1, 0, 0, 5);
        step(1, 1, 0, 5);
        checks++;
        if ({vv[1], ov[1], mi[1], er[1]} !== {1'b1, 24'h050580, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL norelu_neg_sat got %h exp %h", {vv[1], ov[1], mi[1], er[1]}, {1'b1, 24'h050580, 2'd1, 1'b0});
        end
        checks++;
        if ({ov[0], mi[0]} !== {24'h050500, 2'd1}) begin
            errors++;
            $display("FAIL relu_tie got %h exp %h", {ov[0], mi[0]}, {24'h050500, 2'd1});
        end
        step(0, 0, 1, 0);

        step(1, 0, 0, 13);
        step(1, 0, 0, 14);
        step(1, 1, 0, -6);
        checks++;
        if ({vv[2], ov[2], mi[2], er[2]} !== {1'b1, 24'hff0403, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL shift2_round got %h exp %h", {vv[2], ov[2], mi[2], er[2]}, {1'b1, 24'hff0403, 2'd1, 1'b0});
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_short_frame();
        do_reset();
        step(1, 0, 0, 1);
        step(1, 0, 0, 2);
        step(0, 1, 0, 0);
        checks++;
        if ({vv[0], bz[0], er[0]} !== 3'b001) begin
            errors++;
            $display("FAIL short_frame got %b exp 001", {vv[0], bz[0], er[0]});
        end
        step(1, 0, 0, 1);
        step(1, 0, 0, 2);
        step(1, 1, 0, 3);
        checks++;
        if ({vv[0], ov[0], mi[0], er[0]} !== {1'b1, 24'h030201, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL after_short got %h exp %h", {vv[0], ov[0], mi[0], er[0]}, {1'b1, 24'h030201, 2'd2, 1'b1});
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_hold_protect();
        do_reset();
        step(1, 0, 0, 10);
        step(1, 0, 0, 20);
        step(1, 1, 0, 30);
        step(1, 0, 0, 99);
        checks++;
        if ({vv[0], ov[0], mi[0], er[0]} !== {1'b1, 24'h1e140a, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL hold_drop got %h exp %h", {vv[0], ov[0], mi[0], er[0]}, {1'b1, 24'h1e140a, 2'd2, 1'b1});
        end
        do_reset();
        step(1, 0, 0, 7);
        step(1, 0, 0, 8);
        step(1, 1, 0, 9);
        step(1, 0, 1, 99);
        checks++;
        if ({vv[0], er[0], ov[0], bz[0]} !== {1'b0, 1'b1, 24'h090807, 1'b0}) begin
            errors++;
            $display("FAIL hold_valid_ack got %h exp %h", {vv[0], er[0], ov[0], bz[0]}, {1'b0, 1'b1, 24'h090807, 1'b0});
        end
        do_reset();
        step(1, 0, 0, 1);
        step(1, 0, 0, 2);
        step(1, 0, 0, 3);
        step(1, 0, 0, 4);
        step(0, 1, 0, 0);
        checks++;
        if ({vv[0], ov[0], er[0]} !== {1'b1, 24'h030201, 1'b1}) begin
            errors++;
            $display("FAIL overflow_drop got %h exp %h", {vv[0], ov[0], er[0]}, {1'b1, 24'h030201, 1'b1});
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1, 0, 0, 4);
        step(1, 0, 0, 5);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({vv[k], ov[k], mi[k], bz[k], er[k]} !== 29'd0) begin
                errors++;
                $display("FAIL mid_reset dut%0d got %h exp 0", k, {vv[k], ov[k], mi[k], bz[k], er[k]});
            end
        end
        step(1, 0, 0, 4);
        step(1, 0, 0, 5);
        step(1, 1, 0, 6);
        checks++;
        if ({vv[0], ov[0], mi[0], bz[0], er[0]} !== {1'b1, 24'h060504, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_frame got %h exp %h", {vv[0], ov[0], mi[0], bz[0], er[0]},
                     {1'b1, 24'h060504, 2'd2, 1'b0, 1'b0});
        end
        step(0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 6; f++) begin
            step(1, 0, 0, rand_acc());
            step(1, 0, 0, rand_acc());
            step(1, 1, 0, rand_acc());
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({vv[k], ov[k], mi[k], er[k]} !== {1'b1, ref_vec(k), ref_max(k), 1'b0}) begin
                    errors++;
                    $display("FAIL b2b dut%0d frame%0d got %h exp %h", k, f, {vv[k], ov[k], mi[k], er[k]},
                             {1'b1, ref_vec(k), ref_max(k), 1'b0});
                end
            end
            step(0, 0, 1, 0);
        end
    endtask

    task automatic test_random();
        logic [28:0] got, exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 30, rand_acc());
            end
            for (int k = 0; k < 3; k++) begin
                got = {vv[k], ov[k], mi[k], bz[k], er[k]};
                exp = {m_hold, ref_vec(k), ref_max(k), (!m_hold && m_cnt > 0), m_err};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d got %h exp %h", k, c, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_short_frame();
        test_hold_protect();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
